// File: rtl/rvfpm_xif_issue_queue.sv
// CORE-V-XIF issue queue in front of the rvfpm FPU: decodes accept/reject, buffers accepted ops, dispatches in order.
// Optional same-cycle issue-to-dispatch bypass when RVFPM_ISSUE_BYPASS_EN is defined.
`default_nettype none

module rvfpm_xif_issue_queue #(
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         ck,
    input  logic                         rst,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [XLEN-1:0]              issue_instr,
    input  logic [X_ID_WIDTH-1:0]        issue_id,
    output logic                         issue_accept,
    input  logic                         flush,
    output logic                         enable,
    output logic [XLEN-1:0]              instruction,
    output logic [X_ID_WIDTH-1:0]        id,
    input  logic                         fpu_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = XLEN + X_ID_WIDTH;

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           full;
    logic           empty;
    logic           hs_accept;
    logic           push;
    logic           pop;
    logic [EW-1:0]  head;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        issue_accept = 1'b0;
        case (issue_instr[6:0])
            7'b0000111, 7'b0100111, 7'b1000011, 7'b1000111,
            7'b1001011, 7'b1001111, 7'b1010011: issue_accept = 1'b1;
            default:                            issue_accept = 1'b0;
        endcase
    end

    assign issue_ready = !full && !flush && rst;
    assign hs_accept   = issue_valid && issue_ready && issue_accept;
    assign pop         = !empty && fpu_ready;
    assign head        = mem[rd_ptr];

`ifdef RVFPM_ISSUE_BYPASS_EN
    logic bypass;

    // An empty queue forwards the incoming op directly; it is only stored if the FPU stalls.
    assign bypass = empty && hs_accept;
    assign push   = hs_accept && !(bypass && fpu_ready);

    always_comb begin
        enable      = 1'b0;
        instruction = '0;
        id          = '0;
        if (!empty) begin
            enable      = 1'b1;
            instruction = head[EW-1:X_ID_WIDTH];
            id          = head[X_ID_WIDTH-1:0];
        end else if (bypass) begin
            enable      = 1'b1;
            instruction = issue_instr;
            id          = issue_id;
        end
    end
`else
    assign push = hs_accept;

    always_comb begin
        enable      = 1'b0;
        instruction = '0;
        id          = '0;
        if (!empty) begin
            enable      = 1'b1;
            instruction = head[EW-1:X_ID_WIDTH];
            id          = head[X_ID_WIDTH-1:0];
        end
    end
`endif

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge ck) begin
        if (push) begin
            mem[wr_ptr] <= {issue_instr, issue_id};
        end
    end

endmodule

`default_nettype wire

// File: doc/rvfpm_xif_issue_queue.md
Name: rvfpm_xif_issue_queue

Overview:
- Upstream neighbour of the rvfpm FPU core.
- Accepts CORE-V-XIF issue requests, decides accept/reject from the opcode, and buffers accepted instructions with their ids in a FIFO.
- Dispatches the oldest entry to the FPU using the enable / instruction / id / fpu_ready handshake.
- Decouples offload bursts from FPU stalls.

Parameters:
- X_ID_WIDTH, 4, width of CORE-V-XIF instruction id.
- XLEN, 32, instruction word width.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  issue request valid.
- issue_ready  out  1  queue can take a request this cycle.
- issue_instr  in  XLEN  offloaded instruction word.
- issue_id  in  X_ID_WIDTH  instruction id.
- issue_accept  out  1  combinational; meaningful when issue_valid && issue_ready.
- flush  in  1  synchronous clear of all queued entries.
- enable  out  1  dispatch valid towards FPU.
- instruction  out  XLEN  head instruction.
- id  out  X_ID_WIDTH  head id.
- fpu_ready  in  1  FPU takes instruction this cycle.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst=0, async): pointers and count=0, enable=0, instruction=0, id=0, issue_ready=0. After deassertion issue_ready=1.
- Accept decode on issue_instr[6:0]:
  - Accept set: 0000111 LOAD-FP, 0100111 STORE-FP, 1000011, 1000111, 1001011, 1001111, 1010011 OP-FP.
  - Any other opcode: accept=0.
- issue_ready = !full && !flush && rst.
- Issue handshake = issue_valid && issue_ready.
  - Accepted: push {instr,id} at tail.
  - Rejected: handshake completes, nothing stored, count unchanged.
- Dispatch: enable = !empty. instruction/id show the head entry, and read 0 when empty. Transfer = enable && fpu_ready; pops the head at the next edge.
- Outputs stay stable while enable=1 && fpu_ready=0.
- Latency: accepted push at edge N gives enable=1 from cycle N+1 (queue empty, bypass off).
- Ordering: strict FIFO; ids are not checked for uniqueness.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Never occurs when full, since issue_ready=0.
  - Pop from empty is impossible, since enable=0.
- Pointers: log2(DEPTH) bits wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- flush=1 at an edge: pointers and count go to 0, and enable=0 the next cycle.
  - A same-cycle push is blocked (issue_ready=0).
  - A same-cycle dispatch transfer still counts as consumed by the FPU.
- rst asserted mid-operation: all entries are lost immediately and outputs take reset values asynchronously.

Optional Feature:
- Macro RVFPM_ISSUE_BYPASS_EN.
- Defined: when the queue is empty and an accepted handshake occurs, enable=1 in the same cycle with instruction/id = issue_instr/issue_id (combinational path).
  - If fpu_ready=1 that cycle, the entry is not stored and count stays 0.
  - If fpu_ready=0, the entry is stored normally.
  - Gives zero-cycle latency.
- Undefined: no combinational issue-to-dispatch path; minimum latency is 1 cycle as above.

Test Plan:
- Reset then single OP-FP issue (instr 0x00A57553, id 3), fpu_ready=1:
  - issue_accept=1.
  - Next cycle enable=1, instruction=0x00A57553, id=3.
  - Following cycle enable=0, count=0.
- Issue opcode 0110011 (integer OP), id 5 -> issue_accept=0, count stays 0, enable never asserts.
- fpu_ready=0, issue 5 accepted instrs with ids 0..4, DEPTH=4:
  - ids 0-3 accepted; count=4; issue_ready=0 on the 5th request, which is held.
  - Raise fpu_ready: dispatch order 0,1,2,3,4; pointer wrap exercised.
- Count=2, push and pop in the same cycle -> count remains 2; dispatched id is the oldest; new id lands at the tail.
- Count=3, assert flush for one cycle with issue_valid=1 -> issue_ready=0 that cycle; next cycle count=0, enable=0; a later issue dispatches normally.
- Assert rst mid-dispatch with enable=1 -> enable=0, instruction=0, id=0 without waiting for a clock edge. With bypass enabled, empty queue and fpu_ready=1: enable=1 in the issue cycle and count stays 0.
